// File: rtl/posit_adaptive_fault_monitor.sv
// Purpose: compares regime/exponent scale of a full- and a truncated-precision posit sum, flags faults, recommends precision mode.
// Latency: 2 cycles from input handshake to out_valid (decode stage, compare stage).
// Backpressure: elastic valid/ready pipeline; each stage advances when empty or when its downstream advances; in_ready is combinational.
module posit_adaptive_fault_monitor #(
    parameter int FULL_NBITS  = 32,
    parameter int TRUNC_NBITS = 16,
    parameter int ES          = 2,
    parameter int WINDOW      = 16,
    parameter int THRESH      = 4,
    parameter int HOLD        = 32,
    parameter int CNT_W       = 16,
    localparam int SCALE_W    = $clog2(FULL_NBITS) + ES + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FULL_NBITS-1:0]     full_res,
    input  logic [TRUNC_NBITS-1:0]    trunc_res,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_fault,
    output logic signed [SCALE_W-1:0] out_full_scale,
    output logic signed [SCALE_W-1:0] out_trunc_scale,
    output logic                      mode,
    output logic [CNT_W-1:0]          fault_total,
    input  logic                      clr_stats
);

    localparam int WC_W = $clog2(WINDOW) + 1;
    localparam int FW_W = $clog2(THRESH + 1) + 1;
    localparam int HC_W = $clog2(HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                      zero;
        logic                      nar;
        logic signed [SCALE_W-1:0] scale;
    } dec_t;

    typedef enum logic {ST_TRUNC = 1'b0, ST_FULL = 1'b1} state_t;

    // The truncated word is left-aligned into the full width: zero padding
    // behaves exactly like the zero-filled bits beyond the word end, so one
    // decoder serves both formats.
    function automatic dec_t decode(input logic [FULL_NBITS-1:0] x);
        dec_t d;
        logic [FULL_NBITS-1:0] v;
        logic [FULL_NBITS-1:0] rem;
        logic run_bit;
        logic done;
        int m;
        int k;
        int sc;
        d       = '0;
        v       = x[FULL_NBITS-1] ? -x : x;
        run_bit = v[FULL_NBITS-2];
        done    = 1'b0;
        m       = 0;
        for (int i = FULL_NBITS - 2; i >= 0; i--) begin
            if (!done) begin
                if (v[i] == run_bit) m = m + 1;
                else done = 1'b1;
            end
        end
        k   = run_bit ? (m - 1) : -m;
        // skip sign, regime run and terminator; exponent lands in the top bits
        rem = v << (m + 2);
        sc  = k * (2 ** ES) + int'(rem[FULL_NBITS-1 -: ES]);
        if (x[FULL_NBITS-2:0] == '0) begin
            d.zero = !x[FULL_NBITS-1];
            d.nar  = x[FULL_NBITS-1];
        end else begin
            d.scale = SCALE_W'(sc);
        end
        return d;
    endfunction

    logic [FULL_NBITS-1:0] trunc_al;
    dec_t   dec_full, dec_trunc;
    dec_t   s1_full, s1_trunc;
    logic   s1_vld;
    logic   ready_en;
    logic   s1_adv, s2_adv, in_hs, out_hs;
    logic   fault_c;

    state_t            state, state_nx;
    logic [WC_W-1:0]   win_cnt, win_nx;
    logic [FW_W-1:0]   fault_win, fw_nx;
    logic [HC_W-1:0]   hold_cnt, hold_nx;
    logic [FW_W:0]     fw_sum;

    assign trunc_al = {trunc_res, {(FULL_NBITS - TRUNC_NBITS){1'b0}}};
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = ready_en && s1_adv;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign mode     = (state == ST_FULL);

    // Decode both operands and compare the stage-1 results
    always_comb begin
        dec_full  = decode(full_res);
        dec_trunc = decode(trunc_al);
        fault_c   = (s1_full.zero ^ s1_trunc.zero) ||
                    (s1_full.nar ^ s1_trunc.nar) ||
                    (!(s1_full.zero || s1_full.nar || s1_trunc.zero || s1_trunc.nar) &&
                     (s1_full.scale != s1_trunc.scale));
    end

    // Input acceptance opens on the first clock edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Stage 1: decoded scales and special-value flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_full  <= '0;
            s1_trunc <= '0;
        end else if (s1_adv) begin
            s1_vld <= in_hs;
            if (in_hs) begin
                s1_full  <= dec_full;
                s1_trunc <= dec_trunc;
            end
        end
    end

    // Stage 2: comparison result, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_fault       <= 1'b0;
            out_full_scale  <= '0;
            out_trunc_scale <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_fault       <= fault_c;
                out_full_scale  <= s1_full.scale;
                out_trunc_scale <= s1_trunc.scale;
            end
        end
    end

    // Adaptation FSM state and window/hold counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_TRUNC;
            win_cnt   <= '0;
            fault_win <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nx;
            win_cnt   <= win_nx;
            fault_win <= fw_nx;
            hold_cnt  <= hold_nx;
        end
    end

    // Next-state logic: only output handshakes move the FSM
    always_comb begin
        state_nx = state;
        win_nx   = win_cnt;
        fw_nx    = fault_win;
        hold_nx  = hold_cnt;
        fw_sum   = {1'b0, fault_win} + {{FW_W{1'b0}}, out_fault};
        if (out_hs) begin
            case (state)
                ST_TRUNC: begin
                    if (fw_sum >= (FW_W + 1)'(THRESH)) begin
                        // threshold wins over a coincident window rollover
                        state_nx = ST_FULL;
                        hold_nx  = '0;
                    end else if (win_cnt == WC_W'(WINDOW - 1)) begin
                        win_nx = '0;
                        fw_nx  = '0;
                    end else begin
                        win_nx = win_cnt + 1'b1;
                        fw_nx  = fw_sum[FW_W-1:0];
                    end
                end
                ST_FULL: begin
                    if (hold_cnt == HC_W'(HOLD - 1)) begin
                        state_nx = ST_TRUNC;
                        win_nx   = '0;
                        fw_nx    = '0;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                default: state_nx = ST_TRUNC;
            endcase
        end
    end

    // Saturating fault statistics; a clear beats a coincident fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             fault_total <= '0;
        else if (clr_stats)                                     fault_total <= '0;
        else if (out_hs && out_fault && fault_total != CNT_MAX) fault_total <= fault_total + 1'b1;
    end

endmodule

// File: tb/tb_posit_adaptive_fault_monitor.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops on every output handshake.
// A second instance with a 2-bit statistics counter shares all inputs to exercise saturation.
// Status checks (mode, fault_total, in_ready) are made directly by the stimulus process.
module tb_posit_adaptive_fault_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] full_res;
    logic [15:0] trunc_res;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic        out_fault, out_fault2;
    logic signed [7:0] out_full_scale, out_trunc_scale;
    logic signed [7:0] out_full_scale2, out_trunc_scale2;
    logic        mode, mode2;
    logic [15:0] fault_total;
    logic [1:0]  fault_total2;
    logic        clr_stats;

    typedef struct {
        logic f;
        int   fs;
        int   ts;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    posit_adaptive_fault_monitor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .full_res(full_res), .trunc_res(trunc_res), .out_valid(out_valid),
        .out_ready(out_ready), .out_fault(out_fault), .out_full_scale(out_full_scale),
        .out_trunc_scale(out_trunc_scale), .mode(mode), .fault_total(fault_total),
        .clr_stats(clr_stats)
    );

    posit_adaptive_fault_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .full_res(full_res), .trunc_res(trunc_res), .out_valid(out_valid2),
        .out_ready(out_ready), .out_fault(out_fault2), .out_full_scale(out_full_scale2),
        .out_trunc_scale(out_trunc_scale2), .mode(mode2), .fault_total(fault_total2),
        .clr_stats(clr_stats)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs and handshake are stable at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_fault", int'(out_fault), int'(e.f));
                    chk("out_full_scale", int'(out_full_scale), e.fs);
                    chk("out_trunc_scale", int'(out_trunc_scale), e.ts);
                end
            end
        end
    end

    // Issue one transaction; inputs change only 1 time unit after a rising edge
    task automatic send(input logic [31:0] f, input logic [15:0] t,
                        input logic ef, input int efs, input int ets);
        logic ok;
        exp_t e;
        in_valid  = 1'b1;
        full_res  = f;
        trunc_res = t;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.f  = ef;
            e.fs = efs;
            e.ts = ets;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        idle();
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fault_total", int'(fault_total), 0);
        chk("rst_mode", int'(mode), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        full_res  = '0;
        trunc_res = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        #2;
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_mode", int'(mode), 0);
        chk("init_fault_total", int'(fault_total), 0);
        chk("init_out_full_scale", int'(out_full_scale), 0);
        chk("init_in_ready_in_reset", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        // Directed decode vectors: full, trunc, fault, full scale, trunc scale
        send(32'h40000000, 16'h4000, 1'b0,    0,   0);
        send(32'h48000000, 16'h4000, 1'b1,    1,   0);
        send(32'h00000000, 16'h0000, 1'b0,    0,   0);
        send(32'h80000000, 16'h8000, 1'b0,    0,   0);
        send(32'h80000000, 16'h0000, 1'b1,    0,   0);
        send(32'hC0000000, 16'h4000, 1'b0,    0,   0);
        send(32'h20000000, 16'h2000, 1'b0,   -4,  -4);
        send(32'h70000000, 16'h7800, 1'b1,    8,  12);
        send(32'h7FFFFFFF, 16'h7FFF, 1'b1,  120,  56);
        send(32'h00000001, 16'h0001, 1'b1, -120, -56);
        send(32'h58000000, 16'h5800, 1'b0,    3,   3);
        send(32'hB8000000, 16'hB800, 1'b0,    1,   1);
        drain();
        chk("fault_total_vectors", int'(fault_total), 5);
        chk("fault_total_sat", int'(fault_total2), 3);
        chk("mode_after_vectors", int'(mode), 1);

        // Threshold entry, hold exit, window rollover
        pulse_reset();
        repeat (3) send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        drain();
        chk("mode_3_faults", int'(mode), 0);
        send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        drain();
        chk("mode_4_faults", int'(mode), 1);
        chk("fault_total_4", int'(fault_total), 4);
        repeat (31) send(32'h40000000, 16'h4000, 1'b0, 0, 0);
        drain();
        chk("mode_hold_31", int'(mode), 1);
        send(32'h40000000, 16'h4000, 1'b0, 0, 0);
        drain();
        chk("mode_hold_32", int'(mode), 0);
        repeat (13) send(32'h40000000, 16'h4000, 1'b0, 0, 0);
        repeat (6)  send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        repeat (13) send(32'h40000000, 16'h4000, 1'b0, 0, 0);
        drain();
        chk("mode_3_per_window", int'(mode), 0);
        chk("fault_total_10", int'(fault_total), 10);

        // Continuous stream with a 5-cycle consumer stall
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int e1;
                    int e2;
                    e1 = i % 4;
                    e2 = (i / 2) % 4;
                    send(32'h40000000 | (32'(e1) << 27), 16'h4000 | (16'(e2) << 11),
                         (e1 != e2), e1, e2);
                end
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                chk("in_ready_stalled", int'(in_ready), 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages occupied drops the in-flight data
        out_ready = 1'b0;
        send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        idle();
        @(negedge clk);
        chk("both_stages_full", int'(in_ready), 0);
        pulse_reset();
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_output_after_reset", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // Statistics clear coincident with a faulting handshake
        send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        drain();
        chk("fault_total_1", int'(fault_total), 1);
        out_ready = 1'b0;
        send(32'h48000000, 16'h4000, 1'b1, 1, 0);
        idle();
        begin
            int c;
            c = 0;
            @(negedge clk);
            while (!out_valid && c < 50) begin
                @(negedge clk);
                c++;
            end
            chk("clr_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        clr_stats = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        chk("clr_wins", int'(fault_total), 0);
        chk("clr_wins_sat", int'(fault_total2), 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
